// File: rtl/vcve2_pkg.sv
// Shared encodings and helpers for the element-serial vector ALU.
package vcve2_pkg;

    typedef enum logic [3:0] {
        VALU_ADD    = 4'd0,
        VALU_SUB    = 4'd1,
        VALU_AND    = 4'd2,
        VALU_OR     = 4'd3,
        VALU_XOR    = 4'd4,
        VALU_SLL    = 4'd5,
        VALU_SRL    = 4'd6,
        VALU_SRA    = 4'd7,
        VALU_MINU   = 4'd8,
        VALU_MAXU   = 4'd9,
        VALU_MIN    = 4'd10,
        VALU_MAX    = 4'd11,
        VALU_MACC   = 4'd12,
        VALU_REDSUM = 4'd13
    } valu_op_e;

    typedef enum logic [1:0] {
        VSEW_8  = 2'd0,
        VSEW_16 = 2'd1,
        VSEW_32 = 2'd2
    } vsew_e;

    typedef enum logic {
        VALU_IDLE,
        VALU_RUN
    } valu_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= 4'd13;
    endfunction

    function automatic logic sew_legal(input logic [1:0] sew);
        return sew != 2'd3;
    endfunction

    // Elements per 32-bit word for a given element width.
    function automatic logic [2:0] lanes_of(input vsew_e sew);
        case (sew)
            VSEW_8:  return 3'd4;
            VSEW_16: return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    // Keeps the low SEW bits of a word.
    function automatic logic [31:0] sew_mask(input vsew_e sew);
        case (sew)
            VSEW_8:  return 32'h0000_00FF;
            VSEW_16: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational 32-bit SIMD slice: splits a word into SEW lanes, computes
// active lanes independently and passes the old-vd lane through for tails.
module vec_lane_alu
    import vcve2_pkg::*;
(
    input  valu_op_e    i_op,
    input  vsew_e       i_sew,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [3:0]  i_mask,
    output logic [31:0] o_result
);

    logic [31:0] w_elem;

    // One element of width w; operands arrive zero-extended in the low bits.
    function automatic logic [31:0] elem_op(input valu_op_e op, input int unsigned w,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        logic [31:0] m;
        logic [31:0] sa;
        logic [31:0] sb;
        logic [31:0] r;
        logic [4:0]  sh;
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (w)
            8:       begin sa = {{24{a[7]}}, a[7:0]};   sb = {{24{b[7]}}, b[7:0]};   end
            16:      begin sa = {{16{a[15]}}, a[15:0]}; sb = {{16{b[15]}}, b[15:0]}; end
            default: begin sa = a;                      sb = b;                      end
        endcase
        sh = b[4:0] & 5'(w - 1);
        case (op)
            VALU_ADD:  r = a + b;
            VALU_SUB:  r = a - b;
            VALU_AND:  r = a & b;
            VALU_OR:   r = a | b;
            VALU_XOR:  r = a ^ b;
            VALU_SLL:  r = a << sh;
            VALU_SRL:  r = a >> sh;
            VALU_SRA:  r = $signed(sa) >>> sh;
            VALU_MINU: r = (a < b) ? a : b;
            VALU_MAXU: r = (a > b) ? a : b;
            VALU_MIN:  r = ($signed(sa) < $signed(sb)) ? a : b;
            VALU_MAX:  r = ($signed(sa) > $signed(sb)) ? a : b;
            VALU_MACC: r = a * b + c;
            default:   r = c;
        endcase
        return r & m;
    endfunction

    // Per-lane evaluation, segmented by element width.
    always_comb begin
        o_result = i_c;
        w_elem   = '0;
        case (i_sew)
            VSEW_8: begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (i_mask[k]) begin
                        w_elem = elem_op(i_op, 8, {24'b0, i_a[k*8 +: 8]},
                                         {24'b0, i_b[k*8 +: 8]}, {24'b0, i_c[k*8 +: 8]});
                        o_result[k*8 +: 8] = w_elem[7:0];
                    end
                end
            end
            VSEW_16: begin
                for (int unsigned k = 0; k < 2; k++) begin
                    if (i_mask[k]) begin
                        w_elem = elem_op(i_op, 16, {16'b0, i_a[k*16 +: 16]},
                                         {16'b0, i_b[k*16 +: 16]}, {16'b0, i_c[k*16 +: 16]});
                        o_result[k*16 +: 16] = w_elem[15:0];
                    end
                end
            end
            VSEW_32: begin
                if (i_mask[0]) begin
                    w_elem   = elem_op(i_op, 32, i_a, i_b, i_c);
                    o_result = w_elem;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vec_elem_alu.sv
// Element-serial vector execution stage: instruction FSM, element counter,
// tail mask generation and cross-beat integer sum reduction.
module vec_elem_alu
    import vcve2_pkg::*;
#(
    parameter int unsigned ELEN = 32,
    parameter int unsigned VL_W = 10
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [1:0]      sew_i,
    input  logic [VL_W-1:0] vl_i,
    input  logic [ELEN-1:0] seed_i,
    input  logic            beat_i,
    input  logic            last_i,
    input  logic [ELEN-1:0] opa_i,
    input  logic [ELEN-1:0] opb_i,
    input  logic [ELEN-1:0] opc_i,
    output logic [ELEN-1:0] wdata_o,
    output logic            busy_o,
    output logic [ELEN-1:0] red_result_o,
    output logic            red_valid_o,
    output logic            err_o
);

    valu_state_t     r_state;
    valu_state_t     w_state_next;
    valu_op_e        r_op;
    vsew_e           r_sew;
    logic [VL_W-1:0] r_vl;
    logic [VL_W-1:0] r_cnt;
    logic [ELEN-1:0] r_acc;
    logic            r_err;
    logic            r_red_valid;
    logic [ELEN-1:0] r_red_result;

    logic            w_run_beat;
    logic [2:0]      w_lanes;
    logic [3:0]      w_mask;
    logic [ELEN-1:0] w_red_sum;
    logic [ELEN-1:0] w_acc_next;
    logic [VL_W:0]   w_cnt_sum;
    logic [VL_W-1:0] w_cnt_next;
    logic [ELEN-1:0] w_alu_res;

    // A start in the same cycle as a beat wins; the beat belongs to the aborted instruction.
    assign w_run_beat = (r_state == VALU_RUN) && beat_i && !start_i;
    assign w_lanes    = lanes_of(r_sew);
    assign w_cnt_sum  = {1'b0, r_cnt} + (VL_W+1)'(w_lanes);
    assign w_cnt_next = (w_cnt_sum >= {1'b0, r_vl}) ? r_vl : w_cnt_sum[VL_W-1:0];

    // Lane k is active while its element index is below vl; errors force all-tail.
    always_comb begin
        w_mask = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w_mask[k] = !r_err && (3'(k) < w_lanes) &&
                        (({1'b0, r_cnt} + (VL_W+1)'(k)) < {1'b0, r_vl});
        end
    end

    // Sum of the active opa elements of this beat, wrapped to SEW.
    always_comb begin
        w_red_sum = '0;
        case (r_sew)
            VSEW_8: begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (w_mask[k]) w_red_sum = w_red_sum + {24'b0, opa_i[k*8 +: 8]};
                end
            end
            VSEW_16: begin
                for (int unsigned k = 0; k < 2; k++) begin
                    if (w_mask[k]) w_red_sum = w_red_sum + {16'b0, opa_i[k*16 +: 16]};
                end
            end
            VSEW_32: begin
                if (w_mask[0]) w_red_sum = opa_i;
            end
            default: ;
        endcase
        w_acc_next = (r_acc + w_red_sum) & sew_mask(r_sew);
    end

    vec_lane_alu u_lane_alu (
        .i_op     (r_op),
        .i_sew    (r_sew),
        .i_a      (opa_i),
        .i_b      (opb_i),
        .i_c      (opc_i),
        .i_mask   (w_mask),
        .o_result (w_alu_res)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= VALU_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state: start (re)enters RUN from any state; the last beat returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        if (start_i)                        w_state_next = VALU_RUN;
        else if (w_run_beat && last_i)      w_state_next = VALU_IDLE;
    end

    // Instruction context, element counter, accumulator and reduction outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op         <= VALU_ADD;
            r_sew        <= VSEW_8;
            r_vl         <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_err        <= 1'b0;
            r_red_valid  <= 1'b0;
            r_red_result <= '0;
        end else begin
            r_red_valid <= 1'b0;
            if (start_i) begin
                r_op         <= valu_op_e'(op_i);
                r_sew        <= vsew_e'(sew_i);
                r_vl         <= vl_i;
                r_cnt        <= '0;
                r_acc        <= seed_i & sew_mask(vsew_e'(sew_i));
                r_err        <= !op_legal(op_i) || !sew_legal(sew_i);
                r_red_result <= '0;
            end else if (w_run_beat) begin
                r_cnt <= w_cnt_next;
                if (r_op == VALU_REDSUM) begin
                    r_acc <= w_acc_next;
                    if (last_i && !r_err) begin
                        r_red_valid  <= 1'b1;
                        r_red_result <= w_acc_next;
                    end
                end
            end
        end
    end

    assign wdata_o      = w_run_beat ? w_alu_res : opc_i;
    assign busy_o       = (r_state == VALU_RUN);
    assign red_result_o = r_red_result;
    assign red_valid_o  = r_red_valid;
    assign err_o        = r_err;

endmodule

// File: tb/tb_vec_elem_alu.sv
// Self-checking bench for vec_elem_alu: directed scenarios plus a randomised
// per-op sweep against an independent element model.
module tb_vec_elem_alu;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  op_i = '0;
    logic [1:0]  sew_i = '0;
    logic [9:0]  vl_i = '0;
    logic [31:0] seed_i = '0;
    logic        beat_i = 1'b0;
    logic        last_i = 1'b0;
    logic [31:0] opa_i = '0;
    logic [31:0] opb_i = '0;
    logic [31:0] opc_i = '0;
    logic [31:0] wdata_o;
    logic        busy_o;
    logic [31:0] red_result_o;
    logic        red_valid_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    vec_elem_alu #(.ELEN(32), .VL_W(10)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .op_i         (op_i),
        .sew_i        (sew_i),
        .vl_i         (vl_i),
        .seed_i       (seed_i),
        .beat_i       (beat_i),
        .last_i       (last_i),
        .opa_i        (opa_i),
        .opb_i        (opb_i),
        .opc_i        (opc_i),
        .wdata_o      (wdata_o),
        .busy_o       (busy_o),
        .red_result_o (red_result_o),
        .red_valid_o  (red_valid_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference element computed in a 64-bit domain.
    function automatic logic [31:0] ref_elem(input int op, input int w,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        logic [63:0] m, ua, ub, uc, r;
        longint sa, sb;
        int sh;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'b0, a} & m;
        ub = {32'b0, b} & m;
        uc = {32'b0, c} & m;
        sa = $signed(ua << (64 - w)) >>> (64 - w);
        sb = $signed(ub << (64 - w)) >>> (64 - w);
        sh = int'(ub[5:0]) % w;
        case (op)
            0:  r = ua + ub;
            1:  r = ua - ub;
            2:  r = ua & ub;
            3:  r = ua | ub;
            4:  r = ua ^ ub;
            5:  r = ua << sh;
            6:  r = ua >> sh;
            7:  r = sa >>> sh;
            8:  r = (ua < ub) ? ua : ub;
            9:  r = (ua > ub) ? ua : ub;
            10: r = (sa < sb) ? ua : ub;
            11: r = (sa > sb) ? ua : ub;
            12: r = ua * ub + uc;
            default: r = uc;
        endcase
        r = r & m;
        return r[31:0];
    endfunction

    function automatic logic [31:0] ref_word(input int op, input int sew, input int vl,
                                             input int cnt, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
        logic [31:0] res, e;
        int w, n;
        w = 8 << sew;
        n = 32 / w;
        res = c;
        for (int k = 0; k < n; k++) begin
            if (cnt + k < vl) begin
                e = ref_elem(op, w, a >> (k*w), b >> (k*w), c >> (k*w));
                for (int i = 0; i < w; i++) res[k*w + i] = e[i];
            end
        end
        return res;
    endfunction

    task automatic start_instr(input int op, input int sew, input int vl, input logic [31:0] seed);
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = 4'(op); sew_i = 2'(sew); vl_i = 10'(vl); seed_i = seed;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic do_beat(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic last, input logic [31:0] exp, input string name);
        logic [31:0] e;
        opa_i = a; opb_i = b; opc_i = c; beat_i = 1'b1; last_i = last;
        exp_q.push_back(exp);
        @(negedge clk_i);
        e = exp_q.pop_front();
        n_checks++;
        if (wdata_o !== e) begin
            n_fail++;
            $display("FAIL %s: wdata_o=%h expected %h", name, wdata_o, e);
        end
        @(posedge clk_i); #1;
        beat_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        n_checks += 5;
        if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        if (red_valid_o !== 1'b0)  begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", red_valid_o); end
        if (red_result_o !== '0)   begin n_fail++; $display("FAIL reset_rresult: got %h expected 0", red_result_o); end
        if (err_o !== 1'b0)        begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
        if (wdata_o !== '0)        begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", wdata_o); end
    endtask

    task automatic test_add32();
        start_instr(0, 2, 4, 32'h0);
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL add32_busy_run: got %b expected 1", busy_o); end
        for (int k = 0; k < 4; k++)
            do_beat(32'(k), 32'd10, 32'hDEAD_0000, k == 3, 32'(10 + k), "add32");
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL add32_busy_drop: got %b expected 0", busy_o); end
    endtask

    task automatic test_add8_tail();
        start_instr(0, 0, 6, 32'h0);
        do_beat(32'h0101_0101, 32'h0202_0202, 32'hAAAA_AAAA, 1'b0, 32'h0303_0303, "add8_beat0");
        do_beat(32'h0101_0101, 32'h0202_0202, 32'hAAAA_AAAA, 1'b1, 32'hAAAA_0303, "add8_beat1");
    endtask

    task automatic test_sub16();
        start_instr(1, 1, 2, 32'h0);
        do_beat(32'h0000_0001, 32'h0002_0002, 32'h0, 1'b1, 32'hFFFE_FFFF, "sub16_noborrow");
    endtask

    task automatic test_min_minu();
        start_instr(10, 0, 1, 32'h0);
        do_beat(32'h0000_0080, 32'h0000_0001, 32'h0, 1'b1, 32'h0000_0080, "min8_signed");
        start_instr(8, 0, 1, 32'h0);
        do_beat(32'h0000_0080, 32'h0000_0001, 32'h0, 1'b1, 32'h0000_0001, "minu8_unsigned");
    endtask

    task automatic test_redsum();
        start_instr(13, 2, 3, 32'd5);
        for (int k = 0; k < 4; k++)
            do_beat(32'(k + 1), 32'h5555_5555, 32'(32'h100 + k), k == 3, 32'(32'h100 + k), "redsum_wdata");
        n_checks += 3;
        if (red_valid_o !== 1'b1)  begin n_fail++; $display("FAIL redsum_valid: got %b expected 1", red_valid_o); end
        if (red_result_o !== 32'd11) begin n_fail++; $display("FAIL redsum_result: got %0d expected 11", red_result_o); end
        if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL redsum_busy: got %b expected 0", busy_o); end
        @(posedge clk_i); #1;
        n_checks += 2;
        if (red_valid_o !== 1'b0)  begin n_fail++; $display("FAIL redsum_pulse_width: got %b expected 0", red_valid_o); end
        if (red_result_o !== 32'd11) begin n_fail++; $display("FAIL redsum_hold: got %0d expected 11", red_result_o); end
    endtask

    task automatic test_abort_illegal();
        start_instr(13, 2, 4, 32'h0);
        do_beat(32'd1, 32'd0, 32'h11, 1'b0, 32'h11, "abort_pre0");
        do_beat(32'd2, 32'd0, 32'h22, 1'b0, 32'h22, "abort_pre1");
        start_instr(13, 3, 4, 32'h0);
        n_checks += 2;
        if (err_o !== 1'b1)  begin n_fail++; $display("FAIL illegal_sew_err: got %b expected 1", err_o); end
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL illegal_sew_busy: got %b expected 1", busy_o); end
        do_beat(32'd7, 32'd3, 32'h1234_5678, 1'b0, 32'h1234_5678, "illegal_sew_wdata0");
        do_beat(32'd7, 32'd3, 32'h9ABC_DEF0, 1'b1, 32'h9ABC_DEF0, "illegal_sew_wdata1");
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (red_valid_o !== 1'b0) begin n_fail++; $display("FAIL illegal_no_rvalid: got %b expected 0", red_valid_o); end
            @(posedge clk_i); #1;
        end
        start_instr(0, 2, 1, 32'h0);
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err_o); end
        do_beat(32'd4, 32'd5, 32'hFFFF_FFFF, 1'b1, 32'd9, "post_err_add");
        start_instr(14, 0, 4, 32'h0);
        do_beat(32'h0102_0304, 32'h0101_0101, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A, "illegal_op_wdata");
        n_checks++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL illegal_op_sticky: got %b expected 1", err_o); end
    endtask

    task automatic test_vl_zero_idle();
        start_instr(13, 1, 0, 32'h1234_5678);
        do_beat(32'h0000_0FFF, 32'h0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, "vl0_redsum_wdata");
        n_checks += 2;
        if (red_valid_o !== 1'b1)      begin n_fail++; $display("FAIL vl0_rvalid: got %b expected 1", red_valid_o); end
        if (red_result_o !== 32'h5678) begin n_fail++; $display("FAIL vl0_seed: got %h expected 00005678", red_result_o); end
        start_instr(0, 0, 0, 32'h0);
        do_beat(32'h0101_0101, 32'h0101_0101, 32'h7777_7777, 1'b1, 32'h7777_7777, "vl0_add_tail");
        do_beat(32'h0101_0101, 32'h0101_0101, 32'h3333_4444, 1'b1, 32'h3333_4444, "idle_beat_ignored");
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_beat_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_random_ops();
        logic [31:0] a, b, c;
        int vl, n, nb, cnt;
        for (int op = 0; op <= 12; op++) begin
            for (int sew = 0; sew < 3; sew++) begin
                vl  = int'($urandom_range(1, 9));
                n   = 4 >> sew;
                nb  = (vl + n - 1) / n + 1;
                cnt = 0;
                start_instr(op, sew, vl, 32'h0);
                for (int i = 0; i < nb; i++) begin
                    a = $urandom; b = $urandom; c = $urandom;
                    do_beat(a, b, c, i == nb - 1, ref_word(op, sew, vl, cnt, a, b, c), "random_op");
                    cnt = (cnt + n > vl) ? vl : cnt + n;
                end
            end
        end
    endtask

    task automatic test_random_redsum();
        logic [31:0] a, seed, m, acc;
        int vl, n, w, nb, cnt;
        for (int sew = 0; sew < 3; sew++) begin
            w    = 8 << sew;
            n    = 4 >> sew;
            m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
            vl   = int'($urandom_range(1, 10));
            nb   = (vl + n - 1) / n + 1;
            seed = $urandom;
            acc  = seed & m;
            cnt  = 0;
            start_instr(13, sew, vl, seed);
            for (int i = 0; i < nb; i++) begin
                a = $urandom;
                for (int k = 0; k < n; k++)
                    if (cnt + k < vl) acc = (acc + ((a >> (k*w)) & m)) & m;
                do_beat(a, 32'h0, ~a, i == nb - 1, ~a, "random_redsum_wdata");
                cnt = (cnt + n > vl) ? vl : cnt + n;
            end
            n_checks++;
            if (red_valid_o !== 1'b1 || red_result_o !== acc) begin
                n_fail++;
                $display("FAIL random_redsum: valid=%b result=%h expected valid=1 result=%h",
                         red_valid_o, red_result_o, acc);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        start_instr(13, 2, 4, 32'd7);
        do_beat(32'd3, 32'd0, 32'h0, 1'b0, 32'h0, "midreset_beat");
        rst_ni = 1'b0;
        #2;
        n_checks += 2;
        if (busy_o !== 1'b0)     begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy_o); end
        if (red_result_o !== '0) begin n_fail++; $display("FAIL midreset_rresult: got %h expected 0", red_result_o); end
        #1 rst_ni = 1'b1;
        start_instr(13, 2, 1, 32'h0);
        do_beat(32'd9, 32'd0, 32'h0, 1'b1, 32'h0, "postreset_redsum");
        n_checks++;
        if (red_result_o !== 32'd9) begin n_fail++; $display("FAIL postreset_sum: got %0d expected 9", red_result_o); end
    endtask

    initial begin
        test_reset();
        test_add32();
        test_add8_tail();
        test_sub16();
        test_min_minu();
        test_redsum();
        test_abort_illegal();
        test_vl_zero_idle();
        test_random_ops();
        test_random_redsum();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
